// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter.
// FSM state encodings and requester IDs.
package vram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VID  = 2'd1,
      ST_CPU  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic {
      REQ_VID = 1'b0,
      REQ_CPU = 1'b1
   } req_id_e;

endpackage

// File: rtl/vram_cycle_timer.sv
// Loadable down-counter timing one RAM access.
// zero marks the last strobe clock of the access.
module vram_cycle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // Load on grant, then count down and rest at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: video fetch (high prio) vs CPU.
// Arbitrate, access MEM_CYCLES clocks, then one-cycle ack.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 8,
   parameter int MEM_CYCLES    = 2,
   parameter int VID_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_oe,
   output logic              mem_we
);

   localparam int CW = $clog2(MEM_CYCLES) + 1;
   localparam int BW = $clog2(VID_BURST_MAX + 1);
   localparam logic [CW-1:0] CYC_LOAD  = CW'(MEM_CYCLES - 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(VID_BURST_MAX);

   state_e            state_q;
   logic [BW-1:0]     burst_q;
   logic [BW-1:0]     burst_d;
   logic              vid_ack_q;
   logic              cpu_ack_q;
   logic [DATA_W-1:0] vid_data_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_oe_q;
   logic              mem_we_q;

   logic idle;
   logic vid_block;
   logic vid_grant;
   logic cpu_grant;
   logic tmr_zero;

   assign idle      = (state_q == ST_IDLE);
   assign vid_block = cpu_req & (burst_q == BURST_MAX);
   assign vid_grant = idle & vid_req & ~vid_block;
   assign cpu_grant = idle & ~vid_grant & cpu_req;

   vram_cycle_timer #(
      .W(CW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (vid_grant | cpu_grant),
      .load_val (CYC_LOAD),
      .zero     (tmr_zero)
   );

   // Burst count of video grants made while the CPU waits.
   always_comb begin
      burst_d = burst_q;
      if (idle) begin
         if (vid_grant && cpu_req) begin
            if (burst_q != BURST_MAX) begin
               burst_d = burst_q + 1'b1;
            end
         end else if (cpu_grant || !cpu_req) begin
            burst_d = '0;
         end
      end
   end

   // Arbitration FSM with registered strobes, data and acks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         burst_q     <= '0;
         vid_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         vid_data_q  <= '0;
         cpu_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_oe_q    <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         burst_q <= burst_d;
         unique case (state_q)
            ST_IDLE: begin
               if (vid_grant) begin
                  state_q    <= ST_VID;
                  mem_addr_q <= vid_addr;
                  mem_oe_q   <= 1'b1;
               end else if (cpu_grant) begin
                  state_q     <= ST_CPU;
                  mem_addr_q  <= cpu_addr;
                  mem_wdata_q <= cpu_wdata;
                  mem_we_q    <= cpu_we;
                  mem_oe_q    <= ~cpu_we;
               end
            end
            ST_VID: begin
               if (tmr_zero) begin
                  vid_data_q <= mem_rdata;
                  mem_oe_q   <= 1'b0;
                  vid_ack_q  <= 1'b1;
                  state_q    <= ST_DONE;
               end
            end
            ST_CPU: begin
               if (tmr_zero) begin
                  if (!mem_we_q) begin
                     cpu_rdata_q <= mem_rdata;
                  end
                  mem_oe_q  <= 1'b0;
                  mem_we_q  <= 1'b0;
                  cpu_ack_q <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               vid_ack_q <= 1'b0;
               cpu_ack_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign vid_ack   = vid_ack_q;
   assign vid_data  = vid_data_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_oe    = mem_oe_q;
   assign mem_we    = mem_we_q;
   assign cpu_wait  = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter.
// Expected acks are queued by stimulus, checked by a monitor.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_oe;
   logic        mem_we;

   typedef struct {
      bit       vid;
      bit [7:0] data;
      int       at;
   } exp_t;

   exp_t exp_q[$];
   int   tcyc = 0;
   int   n_tot = 0;
   int   n_pass = 0;
   int   t0;

   vram_arbiter #(
      .ADDR_W(16),
      .DATA_W(8),
      .MEM_CYCLES(2),
      .VID_BURST_MAX(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_ack   (vid_ack),
      .vid_data  (vid_data),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .cpu_wait  (cpu_wait),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_oe    (mem_oe),
      .mem_we    (mem_we)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tcyc <= tcyc + 1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h want %h",
                    nm, tcyc, act, req);
   endtask

   task automatic push(input bit v, input bit [7:0] d, input int at);
      exp_t e;
      e.vid  = v;
      e.data = d;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   // Monitor: every ack must match the head of the scoreboard.
   always @(negedge clk) begin
      if (vid_ack === 1'b1 || cpu_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", {vid_ack, cpu_ack}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_excl", 32'(vid_ack & cpu_ack), 0);
            chk("ack_kind", 32'(vid_ack), 32'(e.vid));
            chk("ack_cycle", tcyc, e.at);
            chk("ack_data", e.vid ? vid_data : cpu_rdata, e.data);
         end
      end
   end

   task automatic start();
      @(posedge clk);
      #1;
      t0 = tcyc;
   endtask

   initial begin
      rst = 1'b1;
      vid_req = 0; vid_addr = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      mem_rdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle after reset
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle_outs",
             {vid_ack, vid_data, cpu_ack, cpu_rdata, cpu_wait,
              mem_oe, mem_we},
             0);
         chk("idle_bus", {mem_addr, mem_wdata}, 0);
      end

      // Video read
      start();
      vid_req = 1; vid_addr = 16'h1234; mem_rdata = 8'hA5;
      push(1, 8'hA5, t0 + 3);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("vrd_oe", 32'(mem_oe), 32'(k == 1 || k == 2));
         chk("vrd_we", 32'(mem_we), 0);
         chk("vrd_ack", 32'(vid_ack), 32'(k == 3));
         if (k == 1 || k == 2) chk("vrd_addr", mem_addr, 16'h1234);
         if (k >= 3) chk("vrd_data", vid_data, 8'hA5);
         if (k == 3) vid_req = 0;
      end

      // CPU write
      start();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010;
      cpu_wdata = 8'h5A; mem_rdata = 8'hFF;
      push(0, 8'h00, t0 + 3);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("cwr_we", 32'(mem_we), 32'(k == 1 || k == 2));
         chk("cwr_oe", 32'(mem_oe), 0);
         chk("cwr_wait", 32'(cpu_wait), 32'(k < 3));
         if (k == 1 || k == 2) begin
            chk("cwr_wdata", mem_wdata, 8'h5A);
            chk("cwr_addr", mem_addr, 16'h0010);
         end
         if (k == 3) cpu_req = 0;
      end

      // CPU read
      start();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020; mem_rdata = 8'h3C;
      push(0, 8'h3C, t0 + 3);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("crd_oe", 32'(mem_oe), 32'(k == 1 || k == 2));
         chk("crd_we", 32'(mem_we), 0);
         if (k == 3) cpu_req = 0;
      end

      // Simultaneous requests: video first, then CPU read
      start();
      vid_req = 1; vid_addr = 16'h2000; mem_rdata = 8'h11;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      push(1, 8'h11, t0 + 3);
      push(0, 8'h22, t0 + 7);
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         chk("sim_wait", 32'(cpu_wait), 32'(k < 7));
         if (k == 5 || k == 6) begin
            chk("sim_caddr", mem_addr, 16'h3000);
            chk("sim_coe", 32'(mem_oe), 1);
         end
         if (k == 3) begin
            vid_req = 0;
            mem_rdata = 8'h22;
         end
         if (k == 7) cpu_req = 0;
      end

      // Starvation guard, two rounds to show burst count cleared
      start();
      vid_req = 1; vid_addr = 16'h5000; mem_rdata = 8'h77;
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0055; cpu_wdata = 8'hC3;
      for (int i = 0; i < 4; i++) push(1, 8'h77, t0 + 3 + 4 * i);
      push(0, 8'h22, t0 + 19);
      for (int i = 0; i < 4; i++) push(1, 8'h77, t0 + 23 + 4 * i);
      push(0, 8'h22, t0 + 39);
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         chk("stv_excl", 32'(mem_oe & mem_we), 0);
         if (k == 16) chk("stv_wait", 32'(cpu_wait), 1);
         if (k == 17 || k == 18) begin
            chk("stv_we", 32'(mem_we), 1);
            chk("stv_addr", mem_addr, 16'h0055);
         end
         if (k == 21) chk("stv_vaddr", mem_addr, 16'h5000);
         if (k == 39) begin
            vid_req = 0;
            cpu_req = 0;
         end
      end
      chk("stv_idle", {mem_oe, mem_we, vid_ack, cpu_ack}, 0);

      // Reset mid-access, then a fresh request
      start();
      vid_req = 1; vid_addr = 16'h4444; mem_rdata = 8'h99;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1;
         if (k == 3) begin
            chk("rst_oe", 32'(mem_oe), 0);
            chk("rst_ack", 32'(vid_ack), 0);
            chk("rst_data", vid_data, 0);
            chk("rst_addr", mem_addr, 0);
            push(1, 8'h99, t0 + 6);
            rst = 0;
         end
         if (k == 4 || k == 5) chk("rst_reoe", 32'(mem_oe), 1);
         if (k == 6) vid_req = 0;
         if (k == 7) chk("rst_vdata", vid_data, 8'h99);
      end

      repeat (4) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares the video board's single-ported video RAM between two requesters: the video fetch engine (high priority, deadline-bound) and the CPU bus interface (low priority, stalled with a wait signal).
- Sequences every memory access as arbitrate, then access for MEM_CYCLES clocks, then a one-cycle turnaround/ack.
- Drives the RAM address, data and strobes.
- Bounds CPU starvation with a video burst limit.

Parameters:
- ADDR_W, 16, video RAM address width.
- DATA_W, 8, video RAM data width.
- MEM_CYCLES, 2, clocks the RAM strobes are held per access; must be at least 1.
- VID_BURST_MAX, 4, maximum consecutive video grants while a CPU request is pending.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- vid_req  in  1  video fetch request; held until vid_ack.
- vid_addr  in  ADDR_W  video fetch address.
- vid_ack  out  1  one-cycle pulse; vid_data valid.
- vid_data  out  DATA_W  fetched byte, held until next video ack.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, held until next CPU read ack.
- cpu_wait  out  1  CPU stall, combinational: cpu_req & ~cpu_ack.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- mem_oe  out  1  RAM read strobe, active-high; board-level inversion is done elsewhere.
- mem_we  out  1  RAM write strobe, active-high.

Behaviour:
- Reset: rst has priority over everything.
  - State goes to IDLE; cycle counter and burst_cnt go to 0.
  - All registered outputs (vid_ack, vid_data, cpu_ack, cpu_rdata, mem_addr, mem_wdata, mem_oe, mem_we) go to 0.
  - Any in-flight access is abandoned with no ack.
- States: IDLE, VID, CPU, DONE. The FSM is registered; all outputs except cpu_wait are registered.
- IDLE arbitration, one cycle:
  - If vid_req & ~(cpu_req & burst_cnt==VID_BURST_MAX): go to VID. Latch mem_addr<=vid_addr, set mem_oe<=1, cyc<=MEM_CYCLES-1.
  - Else if cpu_req: go to CPU. Latch mem_addr<=cpu_addr and mem_wdata<=cpu_wdata. Set mem_we<=cpu_we, mem_oe<=~cpu_we, cyc<=MEM_CYCLES-1.
  - Else stay in IDLE.
- VID/CPU:
  - Strobes are held steady for MEM_CYCLES clocks; cyc decrements each clock.
  - At cyc==0, the edge does the following:
    - Capture mem_rdata into vid_data (VID) or cpu_rdata (CPU read only; writes leave cpu_rdata unchanged).
    - Drop mem_oe/mem_we.
    - Pulse the matching ack.
    - Go to DONE.
- DONE: ack high for exactly this one cycle, no arbitration, strobes low (bus turnaround). Next state is IDLE.
- Latency from request seen in IDLE to ack: MEM_CYCLES+1 clocks. Throughput: one access per MEM_CYCLES+2 clocks.
- burst_cnt, evaluated at each IDLE arbitration:
  - On a VID grant with cpu_req=1: increment, saturating at VID_BURST_MAX.
  - On a CPU grant, or when cpu_req=0: clear to 0.
- A requester dropping req mid-access does not abort it: the access completes and the ack still pulses.
- mem_addr and mem_wdata hold their last values while IDLE.
- mem_oe and mem_we are never both high.

Decomposition:
- Shared include file vram_arb_defs.v, with an include guard:
  - state encodings ST_IDLE=2'd0, ST_VID=2'd1, ST_CPU=2'd2, ST_DONE=2'd3;
  - requester IDs for debug.
- One sub-module, vram_cycle_timer:
  - loadable down-counter of width $clog2(MEM_CYCLES)+1;
  - inputs load, load_val;
  - output zero;
  - synchronous rst.

Test Plan (MEM_CYCLES=2, VID_BURST_MAX=4; cycle 0 = first cycle after rst release):
- Idle after reset: no requests for 10 clocks -> every output 0, mem_oe=mem_we=0 throughout.
- Video read: vid_req=1, vid_addr=0x1234 at cycle 0, mem_rdata=0xA5 -> mem_addr=0x1234 and mem_oe=1 in cycles 1-2; vid_ack=1 only in cycle 3; vid_data=0xA5 from cycle 3 onward.
- CPU write: cpu_req=1, cpu_we=1, cpu_addr=0x0010, cpu_wdata=0x5A at cycle 0 -> mem_we=1 with mem_wdata=0x5A in cycles 1-2, mem_oe=0; cpu_ack in cycle 3; cpu_wait=1 in cycles 0-2 and 0 in cycle 3; cpu_rdata unchanged.
- Simultaneous requests: both at cycle 0 -> video ack in cycle 3; CPU granted at IDLE cycle 4; cpu_ack in cycle 7.
- Starvation guard: vid_req and cpu_req held continuously -> exactly 4 video acks (cycles 3, 7, 11, 15), then cpu_ack in cycle 19; burst_cnt is back to 0 after the CPU grant.
- Reset mid-access: video read started at cycle 0, rst=1 in cycle 2 -> no vid_ack; mem_oe=0 from cycle 3; after release, a new vid_req is acked MEM_CYCLES+1 clocks after it is seen.
